// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin scheduler that shares one BFT packet output
// among NUM_OUT_PORTS user streams. Each port has destination config, a
// destination address counter and a credit counter. Only ports with credit
// are granted.
module leaf_out_arbiter #(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned NUM_OUT_PORTS         = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din,
    input  logic [NUM_OUT_PORTS-1:0]              vld_in,
    output logic [NUM_OUT_PORTS-1:0]              ack_out,
    input  logic                                  cfg_we,
    input  logic [NUM_PORT_BITS-1:0]              cfg_idx,
    input  logic                                  cfg_en,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic                                  credit_vld,
    input  logic [NUM_PORT_BITS-1:0]              credit_idx,
    input  logic                                  out_stall,
    output logic [PACKET_BITS-1:0]                dout
);

    localparam int unsigned CW = NUM_ADDR_BITS + 1;
    // One extra bit of headroom so credit + return cannot wrap before clamping.
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(2**NUM_ADDR_BITS);
    localparam logic [CW:0] CREDIT_ADD = (CW+1)'(FREESPACE_UPDATE_SIZE);

    logic                     en_q     [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] port_q   [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] rr_q;

    logic [NUM_OUT_PORTS-1:0] elig;
    logic                     gnt_vld;
    logic [NUM_PORT_BITS-1:0] gnt_idx;
    logic [PACKET_BITS-1:0]   packet;

    // Per-port eligibility: enabled, valid, holding credit, output not stalled.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            elig[i] = en_q[i] & vld_in[i] & (credit_q[i] != '0) & ~out_stall;
        end
    end

    // Round-robin search starting at rr, wrapping at NUM_OUT_PORTS-1.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_OUT_PORTS) idx = idx - NUM_OUT_PORTS;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = NUM_PORT_BITS'(idx);
            end
        end
        ack_out = gnt_vld ? (NUM_OUT_PORTS'(1) << gnt_idx) : '0;
    end

    // Packet assembled from the granted port's current header, address and word.
    always_comb begin
        packet = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt_idx == NUM_PORT_BITS'(i)) begin
                packet = {1'b1, leaf_q[i], port_q[i], addr_q[i],
                          din[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    // Next credit: add return, subtract grant, then clamp to the maximum.
    always_comb begin
        logic [CW:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = {1'b0, credit_q[i]};
            if (credit_vld && (32'(credit_idx) == i)) sum = sum + CREDIT_ADD;
            if (ack_out[i]) sum = sum - 1'b1;
            credit_d[i] = (sum > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : sum[CW-1:0];
        end
    end

    // Output register and round-robin pointer; both frozen while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
            rr_q <= '0;
        end else if (!out_stall) begin
            if (gnt_vld) begin
                dout <= packet;
                rr_q <= (32'(gnt_idx) == NUM_OUT_PORTS - 1) ? '0 : gnt_idx + 1'b1;
            end else begin
                dout <= '0;
            end
        end
    end

    // Per-port config, credit and address state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                en_q[i]     <= 1'b0;
                leaf_q[i]   <= '0;
                port_q[i]   <= '0;
                credit_q[i] <= CREDIT_MAX[CW-1:0];
                addr_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
                if (ack_out[i]) addr_q[i] <= addr_q[i] + 1'b1;
                if (cfg_we && (32'(cfg_idx) == i)) begin
                    en_q[i]   <= cfg_en;
                    leaf_q[i] <= cfg_leaf;
                    port_q[i] <= cfg_port;
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed and random stimulus checked against a
// behavioural model of the round-robin / credit rules.
module tb_leaf_out_arbiter;

    localparam int N  = 7;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*PW-1:0] din;
    logic [N-1:0]    vld_in;
    logic [N-1:0]    ack_out;
    logic            cfg_we;
    logic [3:0]      cfg_idx;
    logic            cfg_en;
    logic [4:0]      cfg_leaf;
    logic [3:0]      cfg_port;
    logic            credit_vld;
    logic [3:0]      credit_idx;
    logic            out_stall;
    logic [48:0]     dout;

    leaf_out_arbiter #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
        .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(N),
        .FREESPACE_UPDATE_SIZE(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .vld_in(vld_in),
        .ack_out(ack_out), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port),
        .credit_vld(credit_vld), .credit_idx(credit_idx),
        .out_stall(out_stall), .dout(dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_en     [N];
    int          m_leaf   [N];
    int          m_port   [N];
    int          m_credit [N];
    int          m_addr   [N];
    int          m_rr;
    logic [48:0] m_dout;
    logic [N-1:0] last_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_leaf[i] = 0; m_port[i] = 0;
            m_credit[i] = 128; m_addr[i] = 0;
        end
        m_rr = 0;
        m_dout = '0;
    endtask

    function automatic int model_grant();
        int p;
        if (out_stall) return -1;
        for (int k = 0; k < N; k++) begin
            p = (m_rr + k) % N;
            if (m_en[p] && vld_in[p] && m_credit[p] > 0) return p;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int c;
        if (!out_stall) begin
            if (g >= 0) begin
                m_dout = {1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_addr[g]), din[g*PW +: PW]};
                m_addr[g] = (m_addr[g] + 1) % 128;
                m_credit[g] = m_credit[g] - 1;
                m_rr = (g + 1) % N;
            end else begin
                m_dout = '0;
            end
        end
        if (credit_vld && int'(credit_idx) < N) begin
            c = int'(credit_idx);
            m_credit[c] = (m_credit[c] + 64 > 128) ? 128 : m_credit[c] + 64;
        end
        if (cfg_we && int'(cfg_idx) < N) begin
            c = int'(cfg_idx);
            m_en[c] = cfg_en; m_leaf[c] = cfg_leaf; m_port[c] = cfg_port;
        end
    endtask

    // One clock: inputs already driven at posedge+1; check ack, then dout.
    task automatic step();
        int g;
        logic [N-1:0] exp_ack;
        #1;
        g = model_grant();
        exp_ack = (g >= 0) ? (N'(1) << g) : '0;
        last_ack = ack_out;
        chk("ack_out", 64'(ack_out), 64'(exp_ack));
        model_update(g);
        @(posedge clk);
        #1;
        chk("dout", 64'(dout), 64'(m_dout));
    endtask

    task automatic idle_inputs();
        vld_in = '0; cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_leaf = '0;
        cfg_port = '0; credit_vld = 0; credit_idx = '0; out_stall = 0;
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) din[i*PW +: PW] = $urandom();
    endtask

    task automatic cfg(input int idx, input bit en, input int leaf, input int port);
        idle_inputs();
        cfg_we = 1; cfg_idx = 4'(idx); cfg_en = en; cfg_leaf = 5'(leaf); cfg_port = 4'(port);
        step();
        cfg_we = 0;
    endtask

    task automatic credit_ret(input int idx);
        idle_inputs();
        credit_vld = 1; credit_idx = 4'(idx);
        step();
        credit_vld = 0;
    endtask

    task automatic count_grants(input logic [N-1:0] v, input int n, input int port, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            vld_in = v;
            rand_din();
            step();
            if (last_ack[port]) cnt++;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        #1;
        model_reset();
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_ack", 64'(ack_out), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        int cnt;
        din = '0;
        idle_inputs();
        reset_n = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset state: everything disabled, no grant even with all valid
        vld_in = '1; rand_din();
        step();

        // Single packet on port 0
        cfg(0, 1, 3, 2);
        idle_inputs();
        vld_in = 7'b0000001;
        din[0 +: PW] = 32'hA5A5A5A5;
        step();
        chk("first_ack", 64'(last_ack), 64'h1);
        chk("first_dout", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5A5A5}));
        idle_inputs();
        step();
        chk("idle_dout", 64'(dout), 64'd0);

        // All ports enabled, continuous traffic
        for (int i = 0; i < N; i++) cfg(i, 1, i + 4, i + 1);
        count_grants('1, 14, 3, cnt);
        chk("rr_port3_count", 64'(cnt), 64'd2);

        // Port 1 credit exhaustion and recovery
        do_reset();
        cfg(1, 1, 9, 5);
        count_grants(7'b0000010, 130, 1, cnt);
        chk("credit_exhaust", 64'(cnt), 64'd128);
        credit_ret(1);
        count_grants(7'b0000010, 70, 1, cnt);
        chk("credit_resume", 64'(cnt), 64'd64);

        // Saturation: returns beyond max, then grant+return at 127
        credit_ret(1); credit_ret(1); credit_ret(1);
        count_grants(7'b0000010, 1, 1, cnt);
        idle_inputs();
        vld_in = 7'b0000010; credit_vld = 1; credit_idx = 4'd1; rand_din();
        step();
        count_grants(7'b0000010, 130, 1, cnt);
        chk("sat_127", 64'(cnt), 64'd128);

        // Credit return at 100 saturates to 128
        credit_ret(1); credit_ret(1);
        count_grants(7'b0000010, 28, 1, cnt);
        credit_ret(1);
        count_grants(7'b0000010, 130, 1, cnt);
        chk("sat_100", 64'(cnt), 64'd128);

        // Stall during traffic
        for (int i = 0; i < N; i++) cfg(i, 1, i, 15 - i);
        credit_ret(1); credit_ret(1);
        count_grants('1, 3, 0, cnt);
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); vld_in = '1; out_stall = 1; rand_din();
            step();
        end
        count_grants('1, 3, 0, cnt);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            idle_inputs();
            vld_in = N'($urandom());
            rand_din();
            out_stall = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) < 15) begin
                credit_vld = 1; credit_idx = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 5) begin
                cfg_we = 1; cfg_idx = 4'($urandom_range(0, 15));
                cfg_en = ($urandom_range(0, 4) != 0);
                cfg_leaf = 5'($urandom()); cfg_port = 4'($urandom());
            end
            step();
        end

        // Mid-stream reset, then fresh state
        idle_inputs(); vld_in = '1; rand_din();
        step();
        do_reset();
        vld_in = '1; rand_din();
        step();
        cfg(2, 1, 17, 6);
        count_grants(7'b0000100, 2, 2, cnt);
        chk("post_reset_grants", 64'(cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin scheduler that shares a leaf's single packet output toward the BFT among its `NUM_OUT_PORTS` user output streams. It runs in the leaf-interface clock domain between the user-side output FIFOs and the BFT output register. Each granted word is packed into a BFT packet whose header comes from per-port destination config. Per-port credit counters track free space at the destination, and the block only grants ports that still have credit.

## Interface
Parameters:
- `PACKET_BITS`, 49: packet width; must equal 1+`NUM_LEAF_BITS`+`NUM_PORT_BITS`+`NUM_ADDR_BITS`+`PAYLOAD_BITS`.
- `PAYLOAD_BITS`, 32: user word width.
- `NUM_LEAF_BITS`, 5: destination leaf field width.
- `NUM_PORT_BITS`, 4: destination port field width; also the width of the port index.
- `NUM_ADDR_BITS`, 7: destination BRAM address field width. Credit max is 2^`NUM_ADDR_BITS`.
- `NUM_OUT_PORTS`, 7: number of requesters, 1..2^`NUM_PORT_BITS`.
- `FREESPACE_UPDATE_SIZE`, 64: credits added per credit return.

Ports:
- `clk`, in, 1: single clock, used for all logic.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `din`, in, `NUM_OUT_PORTS`*`PAYLOAD_BITS`: port i occupies bits [i*`PAYLOAD_BITS` +: `PAYLOAD_BITS`].
- `vld_in`, in, `NUM_OUT_PORTS`: per-port word valid.
- `ack_out`, out, `NUM_OUT_PORTS`: combinational one-hot grant. A word transfers when `vld_in[i]` and `ack_out[i]` are both high.
- `cfg_we`, in, 1: config write strobe.
- `cfg_idx`, in, `NUM_PORT_BITS`: local port index to configure.
- `cfg_en`, in, 1: port enable.
- `cfg_leaf`, in, `NUM_LEAF_BITS`: destination leaf.
- `cfg_port`, in, `NUM_PORT_BITS`: destination port.
- `credit_vld`, in, 1: credit return strobe.
- `credit_idx`, in, `NUM_PORT_BITS`: local port that receives the credit return.
- `out_stall`, in, 1: downstream cannot accept a packet (for example during resend).
- `dout`, out, `PACKET_BITS`: registered packet; MSB is the valid bit.

## Operation
- Per-port state:
  - `en` (reset 0)
  - `leaf` and `port` (reset 0)
  - `credit`, width `NUM_ADDR_BITS`+1 (reset 2^`NUM_ADDR_BITS` = 128)
  - `addr`, width `NUM_ADDR_BITS` (reset 0)
- Round-robin pointer `rr` (reset 0) marks the highest-priority port.
- Eligibility: `elig[i]` = `en[i]` & `vld_in[i]` & (`credit[i]` != 0) & !`out_stall`.
- Grant:
  - Select the first eligible port searching from `rr` upward, wrapping at `NUM_OUT_PORTS`-1 back to 0.
  - `ack_out` is one-hot for that port, or all-zero if no port is eligible.
- On grant g, at the next clock edge:
  - `dout` <= {1'b1, `leaf[g]`, `port[g]`, `addr[g]`, `din[g]`}.
  - `addr[g]` increments, wrapping 127 -> 0.
  - `credit[g]` decrements.
  - `rr` <= g+1, wrapping to 0 after `NUM_OUT_PORTS`-1.
- No grant, `out_stall`=0: `dout` <= 0 and `rr` is unchanged.
- `out_stall`=1: `dout` holds its value, `ack_out`=0, and `rr`, `credit` and `addr` hold. Credit returns and config writes are still applied.
- Credit return: `credit[credit_idx]` += `FREESPACE_UPDATE_SIZE`, saturating at 2^`NUM_ADDR_BITS`.
- Credit return and grant on the same port in the same cycle: net change is +`FREESPACE_UPDATE_SIZE`-1, then saturate.
- Config write: loads `en`, `leaf` and `port` for `cfg_idx` and takes effect from the next cycle. It does not alter `credit` or `addr`.
- A write to a port already granted in that same cycle still sends that packet with the old header.
- Any `cfg_idx` or `credit_idx` >= `NUM_OUT_PORTS` is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight packet is dropped, and `dout`=0 while `reset_n`=0.

## Timing
- `ack_out` is combinational from `vld_in`, `en`, `credit`, `out_stall` and `rr`; there is no registered path from `din`.
- `dout` follows its grant by 1 cycle. Throughput is 1 packet per cycle in total across all ports.
- With all enabled ports continuously valid and holding credit, each port is granted exactly once every `NUM_OUT_PORTS` cycles.
- A port whose credit reaches 0 gets no grant until the cycle after a credit return.
- Reset values: `dout`=0, `ack_out`=0 (`en`=0 at reset).

## Test plan
- Post-reset, enable port 0 (leaf 3, port 2) and assert `vld_in[0]` with `din`=0xA5A5A5A5 for 1 cycle -> `ack_out`=0000001, and the next `dout` = {1, 5'd3, 4'd2, 7'd0, 0xA5A5A5A5}; the cycle after, `dout`=0.
- Enable all 7 ports with all valid for 14 cycles -> grants follow 0,1,…,6,0,…,6, each port's `addr` ends at 2, and `dout` valid every cycle.
- Port 1 valid continuously with no credit return -> exactly 128 grants with `addr` wrapping 127 -> 0 on the last, then `ack_out[1]`=0. One `credit_vld` on port 1 -> grants resume the next cycle, and 64 more are granted.
- Port 1 at credit 127: grant plus credit return in the same cycle -> credit saturates at 128. Credit return at 100 -> 128.
- Hold `out_stall` for 3 cycles during traffic -> `dout` frozen, `ack_out`=0 and `rr` unchanged. On release, arbitration resumes at the same port.
- Drop `reset_n` mid-stream -> `dout`=0 and `ack_out`=0 immediately. After release, ports are disabled with credit 128 and `addr` 0.
